// File: rtl/sb_pkg.sv
// Shared types and constants for the word-granular store buffer.
package sb_pkg;
    localparam int DEPTH_DEFAULT = 4;
    localparam int WORD_SHIFT    = 2;
    localparam int SB_AW         = 32;
    localparam int SB_DW         = 32;

    typedef struct packed {
        logic [SB_AW-WORD_SHIFT-1:0] addr;
        logic [SB_DW-1:0]            data;
        logic [31:0]                 pc;
    } sb_entry_t;
endpackage

// File: rtl/sb_match.sv
// Age-ordered word-address comparator; reports the youngest queued store matching a load.
// Latency: purely combinational.
// Backpressure: none, it only observes buffer state.
module sb_match
    import sb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int PW    = $clog2(DEPTH)
) (
    input  sb_entry_t                   entries [DEPTH],
    input  logic [DEPTH-1:0]            valid,
    input  logic [PW-1:0]               head,
    input  logic [SB_AW-WORD_SHIFT-1:0] ld_word,
    output logic                        hit,
    output logic [PW-1:0]               idx
);
    logic [PW-1:0] slot;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit  = 1'b0;
        idx  = head;
        slot = head;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PW'(k);
            if (valid[slot] && (entries[slot].addr == ld_word)) begin
                hit = 1'b1;
                idx = slot;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// In-order store queue in front of the data memory with load forwarding and port arbitration.
// Latency: stores drain no earlier than the cycle after acceptance; loads complete combinationally.
// Backpressure: st_ready drops when full; ld_stall only when full and the load misses the buffer.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [AW-1:0]             st_addr,
    input  logic [DW-1:0]             st_data,
    input  logic [31:0]               st_pc,
    input  logic                      ld_valid,
    input  logic [AW-1:0]             ld_addr,
    output logic [DW-1:0]             ld_data,
    output logic                      ld_stall,
    output logic                      mem_wr,
    output logic                      mem_rd,
    output logic [AW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_wdata,
    output logic [31:0]               mem_pc,
    input  logic [DW-1:0]             mem_rdata,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        entries [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    age;
    logic             hit;
    logic [PW-1:0]    hit_idx;
    logic             full;
    logic             push;
    logic             pop;
    sb_entry_t        head_e;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = !reset || (cnt == '0);
    assign count    = cnt;
    assign st_ready = reset && !full;
    assign push     = st_valid && st_ready;
    assign pop      = mem_wr;
    assign head_e   = entries[head];

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        valid = '0;
        age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age      = PW'(i) - head;
            valid[i] = ({1'b0, age} < cnt);
        end
    end

    sb_match #(.DEPTH(DEPTH), .PW(PW)) u_match (
        .entries (entries),
        .valid   (valid),
        .head    (head),
        .ld_word (ld_addr[AW-1:WORD_SHIFT]),
        .hit     (hit),
        .idx     (hit_idx)
    );

    always_comb begin
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_pc    = '0;
        ld_data   = '0;
        ld_stall  = 1'b0;
        if (reset) begin
            if (full || (!(ld_valid && !hit) && (cnt != '0))) begin
                // Drain head: forced when full, otherwise whenever no load miss needs the port.
                mem_wr    = 1'b1;
                mem_addr  = {head_e.addr, {WORD_SHIFT{1'b0}}};
                mem_wdata = head_e.data;
                mem_pc    = head_e.pc;
                if (ld_valid) begin
                    if (hit) begin
                        ld_data = entries[hit_idx].data;
                    end else begin
                        ld_stall = 1'b1;
                    end
                end
            end else if (ld_valid && !hit) begin
                mem_rd   = 1'b1;
                mem_addr = ld_addr;
                ld_data  = mem_rdata;
            end else if (ld_valid) begin
                ld_data = entries[hit_idx].data;
            end
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{addr: st_addr[AW-1:WORD_SHIFT], data: st_data, pc: st_pc};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model compared every cycle, directed scenarios, random traffic.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [31:0] st_pc = '0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_pc;
    logic [31:0] mem_rdata;
    logic        empty;
    logic [2:0]  count;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_pc     (st_pc),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_stall  (ld_stall),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_pc    (mem_pc),
        .mem_rdata (mem_rdata),
        .empty     (empty),
        .count     (count)
    );

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(negedge clk) if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: compare mid-cycle, then commit queue/memory changes at the edge.
    initial begin
        logic        hit, e_rdy, e_wr, e_rd, e_stall, pend_pop, pend_push;
        logic [31:0] fwd, e_ld;
        int          n;
        ent_t        pend_ent;
        forever begin
            @(negedge clk);
            #2;
            pend_pop  = 1'b0;
            pend_push = 1'b0;
            pend_ent  = '{a: '0, d: '0, pc: '0};
            if (!rst_n) begin
                q.delete();
                chk("rst_st_ready", 32'(st_ready), 0);
                chk("rst_empty", 32'(empty), 1);
                chk("rst_count", 32'(count), 0);
                chk("rst_mem_wr", 32'(mem_wr), 0);
                chk("rst_mem_rd", 32'(mem_rd), 0);
                chk("rst_ld_stall", 32'(ld_stall), 0);
            end else begin
                n   = q.size();
                hit = 1'b0;
                fwd = '0;
                for (int i = n - 1; i >= 0; i--) begin
                    if (!hit && q[i].a == ld_addr[31:2]) begin
                        hit = 1'b1;
                        fwd = q[i].d;
                    end
                end
                e_rdy = (n != 4);
                e_wr = 1'b0; e_rd = 1'b0; e_stall = 1'b0; e_ld = '0;
                if (n == 4) begin
                    e_wr = 1'b1;
                    if (ld_valid) begin
                        if (hit) e_ld = fwd;
                        else     e_stall = 1'b1;
                    end
                end else if (ld_valid && !hit) begin
                    e_rd = 1'b1;
                    e_ld = ref_mem[ld_addr[9:2]];
                end else begin
                    e_wr = (n > 0);
                    if (ld_valid) e_ld = fwd;
                end
                chk("count", 32'(count), 32'(n));
                chk("empty", 32'(empty), 32'(n == 0));
                chk("st_ready", 32'(st_ready), 32'(e_rdy));
                chk("mem_wr", 32'(mem_wr), 32'(e_wr));
                chk("mem_rd", 32'(mem_rd), 32'(e_rd));
                chk("ld_stall", 32'(ld_stall), 32'(e_stall));
                if (!e_stall) chk("ld_data", ld_data, e_ld);
                if (e_rd) chk("mem_addr_rd", mem_addr, ld_addr);
                if (e_wr) begin
                    chk("mem_addr_wr", mem_addr, {q[0].a, 2'b00});
                    chk("mem_wdata", mem_wdata, q[0].d);
                    chk("mem_pc", mem_pc, q[0].pc);
                end
                pend_pop  = e_wr;
                pend_push = st_valid && e_rdy;
                pend_ent  = '{a: st_addr[31:2], d: st_data, pc: st_pc};
            end
            @(posedge clk);
            if (pend_pop) begin
                ref_mem[q[0].a[7:0]] = q[0].d;
                void'(q.pop_front());
            end
            if (pend_push) q.push_back(pend_ent);
        end
    end

    task automatic cyc(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
        @(posedge clk);
        #1;
        st_valid = sv; st_addr = sa; st_data = sd; st_pc = $urandom;
        ld_valid = lv; ld_addr = la;
        @(negedge clk);
        #3;
    endtask

    task automatic drain();
        int k = 0;
        while (!empty && k < 20) begin
            cyc(1'b0, 0, 0, 1'b0, 0);
            k++;
        end
        chk("drain_empty", 32'(empty), 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3;
        chk("init_st_ready", 32'(st_ready), 0);
        chk("init_empty", 32'(empty), 1);
        chk("init_count", 32'(count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single store drains on the following idle cycle.
        cyc(1'b1, 32'h10, 32'hAAAA0001, 1'b0, 0);
        cyc(1'b0, 0, 0, 1'b0, 0);
        chk("t1_mem_wr", 32'(mem_wr), 1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_wdata", mem_wdata, 32'hAAAA0001);
        cyc(1'b0, 0, 0, 1'b0, 0);
        chk("t1_empty", 32'(empty), 1);
        chk("t1_mem4", mem[4], 32'hAAAA0001);

        // Two stores to one word; youngest forwards.
        cyc(1'b1, 32'h20, 32'h1, 1'b1, 32'h100);
        cyc(1'b1, 32'h20, 32'h2, 1'b1, 32'h104);
        cyc(1'b0, 0, 0, 1'b1, 32'h20);
        chk("t2_ld_data", ld_data, 32'h2);
        chk("t2_ld_stall", 32'(ld_stall), 0);
        drain();

        // Fill under continuous load misses, then push while full.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h200 + 32'(4 * i), 32'(i + 10), 1'b1, 32'h100);
        cyc(1'b1, 32'h210, 32'h77, 1'b1, 32'h100);
        chk("t3_st_ready_full", 32'(st_ready), 0);
        chk("t3_count4", 32'(count), 4);
        chk("t3_ld_stall", 32'(ld_stall), 1);
        chk("t3_mem_wr", 32'(mem_wr), 1);
        cyc(1'b1, 32'h210, 32'h77, 1'b1, 32'h100);
        chk("t3_count3", 32'(count), 3);
        chk("t3_st_ready", 32'(st_ready), 1);
        chk("t3_ld_done", 32'(ld_stall), 0);
        chk("t3_mem_rd", 32'(mem_rd), 1);
        cyc(1'b0, 0, 0, 1'b0, 0);
        chk("t3_accepted", 32'(count), 4);
        drain();
        chk("t3_mem_210", mem[8'h84], 32'h77);

        // Low address bits ignored on forwarding.
        cyc(1'b1, 32'h30, 32'h55, 1'b0, 0);
        cyc(1'b0, 0, 0, 1'b1, 32'h33);
        chk("t4_ld_data", ld_data, 32'h55);
        chk("t4_mem_rd", 32'(mem_rd), 0);
        drain();

        // Reset with three queued stores discards them.
        cyc(1'b1, 32'h300, 32'h1, 1'b1, 32'h104);
        cyc(1'b1, 32'h304, 32'h2, 1'b1, 32'h104);
        cyc(1'b1, 32'h308, 32'h3, 1'b1, 32'h104);
        @(posedge clk);
        #1;
        rst_n = 1'b0; st_valid = 1'b0; ld_valid = 1'b0;
        #1;
        chk("t6_empty", 32'(empty), 1);
        chk("t6_count", 32'(count), 0);
        chk("t6_mem_wr", 32'(mem_wr), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) cyc(1'b0, 0, 0, 1'b0, 0);
        chk("t6_no_stale0", mem[8'hC0], 0);
        chk("t6_no_stale1", mem[8'hC1], 0);
        chk("t6_no_stale2", mem[8'hC2], 0);

        // Random traffic over a small address window to exercise hits, fills and drains.
        for (int i = 0; i < 800; i++) begin
            cyc(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 63)));
        end
        drain();
        for (int i = 0; i < 256; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
